// File: rtl/stream_feeder.sv
// Operand feeder: accepts a job descriptor, emits a one-cycle header, then pops FIFO words on controller strobes.
// Optional build macro STREAM_FEEDER_MSB_GUARD_EN clears readA[7] on data words so only headers carry the start bit.
module stream_feeder #(
  parameter int DEPTH      = 8,
  parameter int GAP_CYCLES = 16
) (
  input  logic       clk,
  input  logic       RST,
  input  logic       job_valid,
  output logic       job_ready,
  input  logic [7:0] job_row_len,
  input  logic [6:0] job_col_tiles,
  input  logic       data_valid,
  output logic       data_ready,
  input  logic [7:0] data_a,
  input  logic [7:0] data_b,
  input  logic [4:0] PERead,
  input  logic [2:0] filtRead,
  output logic [7:0] readA,
  output logic [7:0] readB,
  output logic       busy,
  output logic       underflow
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HEADER = 2'd1,
    STREAM = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]   count_q;
  logic [7:0]      gap_q, gap_d;
  logic            underflow_q, underflow_d;
  logic [7:0]      read_a_q, read_a_d;
  logic [7:0]      read_b_q, read_b_d;

  logic [15:0]     mem [DEPTH];
  logic [15:0]     rd_word;
  logic [7:0]      rd_a;
  logic            strobe;
  logic            fifo_full;
  logic            fifo_empty;
  logic            push;
  logic            pop;

  assign strobe     = (|PERead) | (|filtRead);
  assign fifo_full  = (count_q == CW'(DEPTH));
  assign fifo_empty = (count_q == '0);
  // Pushes are gated only by the registered count, so a same-cycle pop never frees a slot early.
  assign push       = data_valid & ~fifo_full;
  assign rd_word    = mem[rd_ptr_q];

`ifdef STREAM_FEEDER_MSB_GUARD_EN
  assign rd_a = rd_word[15:8] & 8'h7F;
`else
  assign rd_a = rd_word[15:8];
`endif

  always_comb begin
    state_d     = state_q;
    gap_d       = gap_q;
    underflow_d = underflow_q;
    read_a_d    = 8'h00;
    read_b_d    = 8'h00;
    pop         = 1'b0;
    case (state_q)
      IDLE: begin
        if (job_valid) begin
          state_d     = HEADER;
          gap_d       = 8'd0;
          underflow_d = 1'b0;
          read_a_d    = {1'b1, job_row_len[7:1]};
          read_b_d    = {job_row_len[0], job_col_tiles};
        end
      end
      HEADER: begin
        state_d = STREAM;
        gap_d   = 8'd0;
      end
      STREAM: begin
        if (strobe) begin
          gap_d = 8'd0;
          if (!fifo_empty) begin
            pop      = 1'b1;
            read_a_d = rd_a;
            read_b_d = rd_word[7:0];
          end else begin
            underflow_d = 1'b1;
          end
        end else if (gap_q == 8'(GAP_CYCLES - 1)) begin
          state_d = IDLE;
          gap_d   = 8'd0;
        end else begin
          gap_d = gap_q + 8'd1;
        end
      end
      default: begin
        state_d = IDLE;
        gap_d   = 8'd0;
      end
    endcase
  end

  // Storage has no reset so it maps onto plain RAM; validity is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_q] <= {data_a, data_b};
    end
  end

  always_ff @(posedge clk) begin
    if (RST) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      gap_q       <= 8'd0;
      underflow_q <= 1'b0;
      read_a_q    <= 8'h00;
      read_b_q    <= 8'h00;
    end else begin
      state_q     <= state_d;
      gap_q       <= gap_d;
      underflow_q <= underflow_d;
      read_a_q    <= read_a_d;
      read_b_q    <= read_b_d;
      if (push) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign job_ready  = (state_q == IDLE);
  assign busy       = (state_q != IDLE);
  assign data_ready = ~fifo_full;
  assign underflow  = underflow_q;
  assign readA      = read_a_q;
  assign readB      = read_b_q;

endmodule

// File: tb/tb_stream_feeder.sv
// Directed bench for stream_feeder: header, streaming order, underflow, gap timeout, full FIFO, reset, MSB guard.
module tb_stream_feeder;

  logic       clk = 1'b0;
  logic       RST = 1'b1;
  logic       job_valid = 1'b0;
  logic       job_ready;
  logic [7:0] job_row_len = 8'h00;
  logic [6:0] job_col_tiles = 7'h00;
  logic       data_valid = 1'b0;
  logic       data_ready;
  logic [7:0] data_a = 8'h00;
  logic [7:0] data_b = 8'h00;
  logic [4:0] PERead = 5'b0;
  logic [2:0] filtRead = 3'b0;
  logic [7:0] readA;
  logic [7:0] readB;
  logic       busy;
  logic       underflow;

  int vec_cnt = 0;
  int err_cnt = 0;

  stream_feeder #(.DEPTH(8), .GAP_CYCLES(16)) dut (
    .clk(clk), .RST(RST),
    .job_valid(job_valid), .job_ready(job_ready),
    .job_row_len(job_row_len), .job_col_tiles(job_col_tiles),
    .data_valid(data_valid), .data_ready(data_ready),
    .data_a(data_a), .data_b(data_b),
    .PERead(PERead), .filtRead(filtRead),
    .readA(readA), .readB(readB),
    .busy(busy), .underflow(underflow)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    RST = 1'b1;
    tick();
    tick();
    vec_cnt++; if (readA !== 8'h00) begin err_cnt++; $display("FAIL reset_readA: got %h expected 00", readA); end
    vec_cnt++; if (readB !== 8'h00) begin err_cnt++; $display("FAIL reset_readB: got %h expected 00", readB); end
    vec_cnt++; if (busy !== 1'b0) begin err_cnt++; $display("FAIL reset_busy: got %b expected 0", busy); end
    vec_cnt++; if (job_ready !== 1'b1) begin err_cnt++; $display("FAIL reset_job_ready: got %b expected 1", job_ready); end
    vec_cnt++; if (data_ready !== 1'b1) begin err_cnt++; $display("FAIL reset_data_ready: got %b expected 1", data_ready); end
    vec_cnt++; if (underflow !== 1'b0) begin err_cnt++; $display("FAIL reset_underflow: got %b expected 0", underflow); end
    RST = 1'b0;
    tick();
    $display("reset: readA=%h readB=%h busy=%b", readA, readB, busy);
  endtask

  task automatic test_header();
    job_valid = 1'b1; job_row_len = 8'h05; job_col_tiles = 7'h03;
    tick();
    job_valid = 1'b0;
    vec_cnt++; if (readA !== 8'h82) begin err_cnt++; $display("FAIL header_readA: got %h expected 82", readA); end
    vec_cnt++; if (readB !== 8'h83) begin err_cnt++; $display("FAIL header_readB: got %h expected 83", readB); end
    vec_cnt++; if (busy !== 1'b1) begin err_cnt++; $display("FAIL header_busy: got %b expected 1", busy); end
    vec_cnt++; if (job_ready !== 1'b0) begin err_cnt++; $display("FAIL header_job_ready: got %b expected 0", job_ready); end
    tick();
    vec_cnt++; if ({readA, readB} !== 16'h0000) begin err_cnt++; $display("FAIL header_one_cycle: got %h expected 0000", {readA, readB}); end
    $display("header: job 05/03 accepted, header 82/83 shown one cycle");
  endtask

  task automatic test_stream_order();
    data_valid = 1'b1; data_a = 8'h11; data_b = 8'h22;
    tick();
    data_a = 8'h33; data_b = 8'h44;
    tick();
    data_valid = 1'b0;
    PERead = 5'b00001;
    tick();
    vec_cnt++; if ({readA, readB} !== 16'h1122) begin err_cnt++; $display("FAIL stream_word0: got %h expected 1122", {readA, readB}); end
    tick();
    vec_cnt++; if ({readA, readB} !== 16'h3344) begin err_cnt++; $display("FAIL stream_word1: got %h expected 3344", {readA, readB}); end
    PERead = 5'b0;
    tick();
    vec_cnt++; if ({readA, readB} !== 16'h0000) begin err_cnt++; $display("FAIL stream_idle_word: got %h expected 0000", {readA, readB}); end
    vec_cnt++; if (underflow !== 1'b0) begin err_cnt++; $display("FAIL stream_no_underflow: got %b expected 0", underflow); end
    $display("stream: popped 1122 then 3344");
  endtask

  task automatic test_underflow();
    filtRead = 3'b001;
    tick();
    filtRead = 3'b000;
    vec_cnt++; if ({readA, readB} !== 16'h0000) begin err_cnt++; $display("FAIL underflow_word: got %h expected 0000", {readA, readB}); end
    vec_cnt++; if (underflow !== 1'b1) begin err_cnt++; $display("FAIL underflow_set: got %b expected 1", underflow); end
    tick(); tick(); tick();
    vec_cnt++; if (underflow !== 1'b1) begin err_cnt++; $display("FAIL underflow_sticky: got %b expected 1", underflow); end
    $display("underflow: strobe on empty FIFO, flag=%b", underflow);
  endtask

  task automatic test_gap();
    PERead = 5'b00100;
    tick();
    PERead = 5'b0;
    for (int i = 0; i < 15; i++) tick();
    vec_cnt++; if (busy !== 1'b1) begin err_cnt++; $display("FAIL gap15_busy: got %b expected 1", busy); end
    filtRead = 3'b100;
    tick();
    filtRead = 3'b000;
    vec_cnt++; if (busy !== 1'b1) begin err_cnt++; $display("FAIL gap_restart_busy: got %b expected 1", busy); end
    for (int i = 0; i < 15; i++) tick();
    vec_cnt++; if (busy !== 1'b1) begin err_cnt++; $display("FAIL gap_before_timeout: got %b expected 1", busy); end
    tick();
    vec_cnt++; if (busy !== 1'b0) begin err_cnt++; $display("FAIL gap_timeout_busy: got %b expected 0", busy); end
    vec_cnt++; if (job_ready !== 1'b1) begin err_cnt++; $display("FAIL gap_timeout_job_ready: got %b expected 1", job_ready); end
    vec_cnt++; if (underflow !== 1'b1) begin err_cnt++; $display("FAIL gap_underflow_held: got %b expected 1", underflow); end
    $display("gap: restart at 15, IDLE after 16 strobe-free cycles");
  endtask

  task automatic test_full_fifo();
    for (int i = 0; i < 8; i++) begin
      data_valid = 1'b1; data_a = 8'h40 + 8'(i); data_b = 8'h80 + 8'(i);
      tick();
      vec_cnt++;
      if (data_ready !== (i < 7)) begin
        err_cnt++; $display("FAIL fill_data_ready_%0d: got %b expected %b", i, data_ready, (i < 7));
      end
    end
    data_a = 8'h3F; data_b = 8'h3F;
    tick();
    data_valid = 1'b0;
    vec_cnt++; if (data_ready !== 1'b0) begin err_cnt++; $display("FAIL full_hold: got %b expected 0", data_ready); end
    job_valid = 1'b1; job_row_len = 8'h10; job_col_tiles = 7'h01; PERead = 5'b10000;
    tick();
    job_valid = 1'b0;
    vec_cnt++; if ({readA, readB} !== 16'h8801) begin err_cnt++; $display("FAIL full_header: got %h expected 8801", {readA, readB}); end
    vec_cnt++; if (underflow !== 1'b0) begin err_cnt++; $display("FAIL accept_clears_underflow: got %b expected 0", underflow); end
    vec_cnt++; if (data_ready !== 1'b0) begin err_cnt++; $display("FAIL idle_strobe_no_pop: got %b expected 0", data_ready); end
    tick();
    vec_cnt++; if ({readA, readB} !== 16'h0000) begin err_cnt++; $display("FAIL header_strobe_ignored: got %h expected 0000", {readA, readB}); end
    vec_cnt++; if (data_ready !== 1'b0) begin err_cnt++; $display("FAIL header_strobe_no_pop: got %b expected 0", data_ready); end
    tick();
    vec_cnt++; if ({readA, readB} !== 16'h4080) begin err_cnt++; $display("FAIL full_pop0: got %h expected 4080", {readA, readB}); end
    vec_cnt++; if (data_ready !== 1'b1) begin err_cnt++; $display("FAIL full_pop0_ready: got %b expected 1", data_ready); end
    data_valid = 1'b1; data_a = 8'h55; data_b = 8'h66;
    tick();
    vec_cnt++; if ({readA, readB} !== 16'h4181) begin err_cnt++; $display("FAIL pushpop_word: got %h expected 4181", {readA, readB}); end
    vec_cnt++; if (data_ready !== 1'b1) begin err_cnt++; $display("FAIL pushpop_ready: got %b expected 1", data_ready); end
    PERead = 5'b0; data_a = 8'h57; data_b = 8'h68;
    tick();
    data_valid = 1'b0;
    vec_cnt++; if (data_ready !== 1'b0) begin err_cnt++; $display("FAIL pushpop_count7: got %b expected 0", data_ready); end
    vec_cnt++; if ({readA, readB} !== 16'h0000) begin err_cnt++; $display("FAIL pushpop_after: got %h expected 0000", {readA, readB}); end
    for (int i = 0; i < 15; i++) tick();
    vec_cnt++; if (busy !== 1'b0) begin err_cnt++; $display("FAIL full_job_end: got %b expected 0", busy); end
    job_valid = 1'b1; job_row_len = 8'h05; job_col_tiles = 7'h03;
    tick();
    job_valid = 1'b0;
    vec_cnt++; if ({readA, readB} !== 16'h8283) begin err_cnt++; $display("FAIL second_header: got %h expected 8283", {readA, readB}); end
    tick();
    PERead = 5'b00010;
    tick();
    PERead = 5'b0;
    vec_cnt++; if ({readA, readB} !== 16'h4282) begin err_cnt++; $display("FAIL persist_word: got %h expected 4282", {readA, readB}); end
    $display("full_fifo: fill to 8, push+pop holds count, contents persist across jobs");
  endtask

  task automatic test_reset_mid_stream();
    PERead = 5'b00001; RST = 1'b1;
    tick();
    RST = 1'b0; PERead = 5'b0;
    vec_cnt++; if ({readA, readB} !== 16'h0000) begin err_cnt++; $display("FAIL midrst_word: got %h expected 0000", {readA, readB}); end
    vec_cnt++; if (busy !== 1'b0) begin err_cnt++; $display("FAIL midrst_busy: got %b expected 0", busy); end
    vec_cnt++; if (data_ready !== 1'b1) begin err_cnt++; $display("FAIL midrst_flush: got %b expected 1", data_ready); end
    vec_cnt++; if (job_ready !== 1'b1) begin err_cnt++; $display("FAIL midrst_job_ready: got %b expected 1", job_ready); end
    tick();
    $display("reset_mid_stream: FIFO discarded, busy=%b", busy);
  endtask

  task automatic test_msb_guard();
    logic [7:0] exp_a;
`ifdef STREAM_FEEDER_MSB_GUARD_EN
    exp_a = 8'h70;
`else
    exp_a = 8'hF0;
`endif
    data_valid = 1'b1; data_a = 8'hF0; data_b = 8'h5A;
    tick();
    data_valid = 1'b0;
    job_valid = 1'b1; job_row_len = 8'hFF; job_col_tiles = 7'h7F;
    tick();
    job_valid = 1'b0;
    vec_cnt++; if ({readA, readB} !== 16'hFFFF) begin err_cnt++; $display("FAIL guard_header: got %h expected FFFF", {readA, readB}); end
    tick();
    filtRead = 3'b010;
    tick();
    filtRead = 3'b000;
    vec_cnt++; if (readA !== exp_a) begin err_cnt++; $display("FAIL guard_readA: got %h expected %h", readA, exp_a); end
    vec_cnt++; if (readB !== 8'h5A) begin err_cnt++; $display("FAIL guard_readB: got %h expected 5a", readB); end
    $display("msb_guard: data F0/5A streamed as %h/%h", readA, readB);
  endtask

  initial begin
    test_reset();
    test_header();
    test_stream_order();
    test_underflow();
    test_gap();
    test_full_fifo();
    test_reset_mid_stream();
    test_msb_guard();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
